// File: rtl/mask_pkg.sv
// Shared widths and FSM encoding for the mask centroid stage.
package mask_pkg;

    localparam int COORD_W = 10;
    localparam int SUM_W   = 30;
    localparam int CNT_W   = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mask_centroid_if.sv
// Pixel-stream inputs and centroid result outputs of the mask centroid stage.
interface mask_centroid_if;
    import mask_pkg::*;

    logic               median;
    logic               de;
    logic               vsync;
    logic               hsync;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic               found;
    logic               done;

    modport master (
        output median, de, vsync, hsync,
        input  cx, cy, found, done
    );

    modport slave (
        input  median, de, vsync, hsync,
        output cx, cy, found, done
    );

endinterface

// File: rtl/mask_centroid_seq_divider.sv
// Restoring divider, one quotient bit per clock, MSB first; the first bit
// is resolved on the start edge straight from the dividend/divisor inputs.
module seq_divider
    import mask_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic [SUM_W-1:0] quotient
);

    localparam int STEP_W = $clog2(SUM_W);

    logic [CNT_W-1:0]  rem_p1, dsr_p1, src_rem, src_dsr, rem_nxt;
    logic [SUM_W-1:0]  dvd_p1, q_p1, src_dvd;
    logic [CNT_W:0]    trial, diff;
    logic              ge;
    logic [STEP_W-1:0] steps;

    always_comb begin
        src_rem = start ? '0 : rem_p1;
        src_dvd = start ? dividend : dvd_p1;
        src_dsr = start ? divisor : dsr_p1;
        trial   = {src_rem, src_dvd[SUM_W-1]};
        diff    = trial - {1'b0, src_dsr};
        // No borrow out of the trial subtraction means the divisor fits.
        ge      = ~diff[CNT_W];
        rem_nxt = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_p1 <= '0;
            dsr_p1 <= '0;
            dvd_p1 <= '0;
            q_p1   <= '0;
            steps  <= '0;
            busy   <= 1'b0;
        end else if (start || busy) begin
            rem_p1 <= rem_nxt;
            dsr_p1 <= src_dsr;
            dvd_p1 <= {src_dvd[SUM_W-2:0], 1'b0};
            q_p1   <= start ? SUM_W'(ge) : {q_p1[SUM_W-2:0], ge};
            if (start) begin
                busy  <= 1'b1;
                steps <= STEP_W'(SUM_W - 1);
            end else begin
                steps <= steps - STEP_W'(1);
                if (steps == STEP_W'(1)) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    assign quotient = q_p1;

endmodule

// File: rtl/mask_centroid.sv
// Accumulates mask-pixel coordinates per frame and reports the blob
// centroid (floor of mean x/y) a fixed latency after each vsync rise.
module mask_centroid
    import mask_pkg::*;
#(
    parameter int H_SIZE     = 83,
    parameter int V_SIZE     = 64,
    parameter int MIN_PIXELS = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    mask_centroid_if.slave bus
);

    localparam logic [COORD_W:0] H_LIM   = (COORD_W + 1)'(H_SIZE);
    localparam logic [COORD_W:0] V_LIM   = (COORD_W + 1)'(V_SIZE);
    localparam logic [CNT_W:0]   MIN_CNT = (CNT_W + 1)'(MIN_PIXELS);

    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (v == '1) ? v : v + COORD_W'(1);
    endfunction

    function automatic logic [COORD_W-1:0] sat_coord(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:COORD_W]) ? '1 : q[COORD_W-1:0];
    endfunction

    logic               vsync_p1, de_p1;
    logic [COORD_W-1:0] x, y;
    logic [SUM_W-1:0]   sum_x, sum_y;
    logic [CNT_W-1:0]   cnt;
    logic               frame_end, hit, cnt_ok, div_start;
    logic               busy_x, busy_y;
    logic [SUM_W-1:0]   q_x, q_y;
    state_t             state;
    logic               found_next;
    logic [COORD_W-1:0] cx_r, cy_r;
    logic               found_r, done_r;
    logic               unused_sig;

    assign frame_end = bus.vsync && !vsync_p1;
    assign hit       = bus.de && bus.median && ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
    assign cnt_ok    = {1'b0, cnt} >= MIN_CNT;
    assign div_start = frame_end && cnt_ok;
    assign unused_sig = bus.hsync ^ busy_y;

    // Stage 1: coordinate tracking and per-frame accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_p1 <= 1'b0;
            de_p1    <= 1'b0;
            x        <= '0;
            y        <= '0;
            sum_x    <= '0;
            sum_y    <= '0;
            cnt      <= '0;
        end else begin
            vsync_p1 <= bus.vsync;
            de_p1    <= bus.de;
            if (frame_end) begin
                x     <= '0;
                y     <= '0;
                sum_x <= '0;
                sum_y <= '0;
                cnt   <= '0;
            end else begin
                if (hit) begin
                    sum_x <= sum_x + SUM_W'(x);
                    sum_y <= sum_y + SUM_W'(y);
                    cnt   <= cnt + CNT_W'(1);
                end
                if (bus.de) begin
                    x <= sat_inc(x);
                end else if (de_p1) begin
                    x <= '0;
                    y <= sat_inc(y);
                end
            end
        end
    end

    // Stage 2: frame-end division
    seq_divider u_div_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (sum_x),
        .divisor  (cnt),
        .busy     (busy_x),
        .quotient (q_x)
    );

    seq_divider u_div_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (sum_y),
        .divisor  (cnt),
        .busy     (busy_y),
        .quotient (q_y)
    );

    // Stage 3: result sequencing; a new frame end always wins over an in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            found_next <= 1'b0;
            cx_r       <= '0;
            cy_r       <= '0;
            found_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (frame_end) begin
                state      <= cnt_ok ? DIV : DONE;
                found_next <= cnt_ok;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    DIV: begin
                        if (!busy_x) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        done_r  <= 1'b1;
                        found_r <= found_next;
                        if (found_next) begin
                            cx_r <= sat_coord(q_x);
                            cy_r <= sat_coord(q_y);
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.cx    = cx_r;
    assign bus.cy    = cy_r;
    assign bus.found = found_r;
    assign bus.done  = done_r;

endmodule

// File: tb/tb_mask_centroid.sv
// Directed-frame bench for mask_centroid: two instances (MIN_PIXELS 1 and 16)
// share one pixel stream and are checked every cycle against a frame-level model.
module tb_mask_centroid;
    import mask_pkg::*;

    localparam int H = 83;
    localparam int V = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic de = 1'b0, median = 1'b0, vsync = 1'b0, hsync = 1'b0;

    mask_centroid_if if1 ();
    mask_centroid_if if16 ();

    assign if1.de      = de;
    assign if1.median  = median;
    assign if1.vsync   = vsync;
    assign if1.hsync   = hsync;
    assign if16.de     = de;
    assign if16.median = median;
    assign if16.vsync  = vsync;
    assign if16.hsync  = hsync;

    mask_centroid #(.H_SIZE(H), .V_SIZE(V), .MIN_PIXELS(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    mask_centroid #(.H_SIZE(H), .V_SIZE(V), .MIN_PIXELS(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       dn[2];
    logic [9:0] ocx[2], ocy[2];
    logic       ofd[2];
    assign dn[0]  = if1.done;
    assign dn[1]  = if16.done;
    assign ocx[0] = if1.cx;
    assign ocx[1] = if16.cx;
    assign ocy[0] = if1.cy;
    assign ocy[1] = if16.cy;
    assign ofd[0] = if1.found;
    assign ofd[1] = if16.found;

    int n_tests = 0;
    int n_fail  = 0;

    bit pix [0:69][0:95];
    int cur_lines, cur_width;
    int thr[2] = '{1, 16};
    int pend_v[2], pend_cyc[2], pend_found[2], pend_cx[2], pend_cy[2];
    int exp_cx[2], exp_cy[2], exp_found[2], last_done[2];
    int e_last;

    task automatic chk(input string name, input int k, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s dut%0d @cyc %0d: got %0d, want %0d", name, (k == 0) ? 1 : 16, cyc, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit d, input bit m, input bit v);
        de     = d;
        median = m;
        vsync  = v;
        hsync  = !d && !v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic clear_pix();
        for (int l = 0; l < 70; l++)
            for (int p = 0; p < 96; p++)
                pix[l][p] = 1'b0;
    endtask

    task automatic send_lines(input int nl, input int w);
        cur_lines = nl;
        cur_width = w;
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < w; p++) begin
                tick();
                drive(1'b1, pix[l][p], 1'b0);
            end
            idle(2);
        end
    endtask

    // Frame end: the model derives the frame result from the drawn pixel map.
    task automatic pulse(input bit drop);
        int c;
        longint sx, sy;
        tick();
        drive(drop, drop, 1'b1);
        e_last = cyc + 1;
        c = 0;
        sx = 0;
        sy = 0;
        for (int l = 0; l < cur_lines && l < V; l++)
            for (int p = 0; p < cur_width && p < H; p++)
                if (pix[l][p]) begin
                    c++;
                    sx += p;
                    sy += l;
                end
        for (int k = 0; k < 2; k++) begin
            pend_v[k]     = 1;
            pend_found[k] = (c >= thr[k]) ? 1 : 0;
            pend_cyc[k]   = e_last + ((pend_found[k] != 0) ? 31 : 1);
            pend_cx[k]    = (c > 0) ? int'((sx / c > 1023) ? 1023 : sx / c) : 0;
            pend_cy[k]    = (c > 0) ? int'((sy / c > 1023) ? 1023 : sy / c) : 0;
        end
        tick(); drive(1'b0, 1'b0, 1'b1);
        tick(); drive(1'b0, 1'b0, 1'b1);
        tick(); drive(1'b0, 1'b0, 1'b0);
        tick(); drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pend_v[k]    = 0;
            exp_cx[k]    = 0;
            exp_cy[k]    = 0;
            exp_found[k] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int k = 0; k < 2; k++) begin
                automatic int want_done = (pend_v[k] != 0 && cyc == pend_cyc[k]) ? 1 : 0;
                chk("done", k, int'(dn[k]), want_done);
                if (want_done != 0) begin
                    pend_v[k]    = 0;
                    last_done[k] = cyc;
                    exp_found[k] = pend_found[k];
                    if (pend_found[k] != 0) begin
                        exp_cx[k] = pend_cx[k];
                        exp_cy[k] = pend_cy[k];
                    end
                end
                chk("cx", k, int'(ocx[k]), exp_cx[k]);
                chk("cy", k, int'(ocy[k]), exp_cy[k]);
                chk("found", k, int'(ofd[k]), exp_found[k]);
            end
        end
    end

    initial begin
        model_reset();
        last_done[0] = -1;
        last_done[1] = -1;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_cx", k, int'(ocx[k]), 0);
            chk("rst_cy", k, int'(ocy[k]), 0);
            chk("rst_found", k, int'(ofd[k]), 0);
            chk("rst_done", k, int'(dn[k]), 0);
        end
        rst_n = 1'b1;
        idle(3);

        // Single pixel at (5,3)
        clear_pix();
        pix[3][5] = 1'b1;
        send_lines(4, 8);
        pulse(1'b0);
        idle(40);
        chk("t1_cx", 0, int'(ocx[0]), 5);
        chk("t1_cy", 0, int'(ocy[0]), 3);
        chk("t1_found", 0, int'(ofd[0]), 1);
        chk("t1_lat", 0, last_done[0] - e_last, 31);
        chk("t1_found", 1, int'(ofd[1]), 0);
        chk("t1_lat", 1, last_done[1] - e_last, 1);

        // 2x2 block at x=10..11, y=20..21; a mask pixel on the vsync edge must be dropped
        clear_pix();
        pix[20][10] = 1'b1; pix[20][11] = 1'b1;
        pix[21][10] = 1'b1; pix[21][11] = 1'b1;
        send_lines(22, 12);
        pulse(1'b1);
        idle(40);
        chk("t2_cx", 0, int'(ocx[0]), 10);
        chk("t2_cy", 0, int'(ocy[0]), 20);
        chk("t2_found", 0, int'(ofd[0]), 1);

        // Empty frame: found drops, centroid holds
        clear_pix();
        send_lines(2, 4);
        pulse(1'b0);
        idle(40);
        chk("t3_found", 0, int'(ofd[0]), 0);
        chk("t3_cx", 0, int'(ocx[0]), 10);
        chk("t3_cy", 0, int'(ocy[0]), 20);
        chk("t3_lat", 0, last_done[0] - e_last, 1);

        // 15 pixels: below the 16 threshold
        clear_pix();
        for (int p = 0; p < 15; p++) pix[2][p] = 1'b1;
        send_lines(3, 16);
        pulse(1'b0);
        idle(40);
        chk("t4_found", 1, int'(ofd[1]), 0);
        chk("t4_cx", 0, int'(ocx[0]), 7);
        chk("t4_cy", 0, int'(ocy[0]), 2);

        // 16 pixels: sum_x 456, sum_y 88 -> (28,5)
        clear_pix();
        for (int p = 20; p < 28; p++) pix[4][p] = 1'b1;
        for (int p = 30; p < 38; p++) pix[7][p] = 1'b1;
        send_lines(8, 40);
        pulse(1'b0);
        idle(40);
        chk("t5_found", 1, int'(ofd[1]), 1);
        chk("t5_cx", 1, int'(ocx[1]), 28);
        chk("t5_cy", 1, int'(ocy[1]), 5);
        chk("t5_lat", 1, last_done[1] - e_last, 31);

        // Bounds: x=85 and y=64 ignored, (82,1) and (4,63) counted
        clear_pix();
        pix[1][82] = 1'b1;
        pix[1][85] = 1'b1;
        pix[63][4] = 1'b1;
        pix[64][3] = 1'b1;
        send_lines(65, 90);
        pulse(1'b0);
        idle(40);
        chk("t6_cx", 0, int'(ocx[0]), 43);
        chk("t6_cy", 0, int'(ocy[0]), 32);

        // Second frame end 10 cycles after the first abandons frame 1
        clear_pix();
        pix[3][5] = 1'b1;
        send_lines(4, 8);
        pulse(1'b0);
        begin
            automatic int e1 = e_last;
            clear_pix();
            pix[0][1] = 1'b1;
            send_lines(1, 3);
            pulse(1'b0);
            chk("t7_gap", 0, e_last - e1, 10);
        end
        idle(40);
        chk("t7_lat", 0, last_done[0] - e_last, 31);
        chk("t7_cx", 0, int'(ocx[0]), 1);
        chk("t7_cy", 0, int'(ocy[0]), 0);

        // Reset at cycle 15 of DIV, then a full frame
        clear_pix();
        pix[3][5] = 1'b1;
        send_lines(4, 8);
        pulse(1'b0);
        while (cyc < e_last + 15) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t8_rst_found", 0, int'(ofd[0]), 0);
        chk("t8_rst_cx", 0, int'(ocx[0]), 0);
        chk("t8_rst_done", 0, int'(dn[0]), 0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_pix();
        pix[20][10] = 1'b1; pix[20][11] = 1'b1;
        pix[21][10] = 1'b1; pix[21][11] = 1'b1;
        send_lines(22, 12);
        pulse(1'b0);
        idle(40);
        chk("t8_cx", 0, int'(ocx[0]), 10);
        chk("t8_cy", 0, int'(ocy[0]), 20);
        chk("t8_found", 0, int'(ofd[0]), 1);
        chk("t8_cx", 1, int'(ocx[1]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
